// File: rtl/c2h_pattern_gen.sv
// C2H AXI4-Stream source: num_pkts packets of pkt_len bytes, each PATT_WIDTH slice = seed + pkt + beat*SPB + slice.
// First beat valid 1 cycle after accepted start, 1 beat/cycle; registered outputs hold while tvalid && !tready.
module c2h_pattern_gen #(
    parameter int DATA_WIDTH = 512,
    parameter int PATT_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    user_clk,
    input  logic                    user_reset_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    pkt_len,
    input  logic [CNT_WIDTH-1:0]    num_pkts,
    input  logic [PATT_WIDTH-1:0]   seed,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    localparam int BPB = DATA_WIDTH / 8;
    localparam int SPB = DATA_WIDTH / PATT_WIDTH;
    localparam int SB  = PATT_WIDTH / 8;

    localparam logic [LEN_WIDTH:0]    BPB_X = (LEN_WIDTH+1)'(BPB);
    localparam logic [LEN_WIDTH-1:0]  BPB_L = LEN_WIDTH'(BPB);
    localparam logic [LEN_WIDTH-1:0]  SB_L  = LEN_WIDTH'(SB);
    localparam logic [PATT_WIDTH-1:0] SPB_P = PATT_WIDTH'(SPB);

    typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;

    state_t                  r_state;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_rem;
    logic [CNT_WIDTH-1:0]    r_pkts_left;
    logic [PATT_WIDTH-1:0]   r_pbase;
    logic [PATT_WIDTH-1:0]   r_base;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic [BPB-1:0]          r_tkeep;
    logic                    r_tlast;
    logic                    r_tvalid;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_cfg_err;

    logic                    w_cfg_ok;
    logic                    w_acc;
    logic                    w_cur_last;
    logic                    w_run_end;
    logic [PATT_WIDTH-1:0]   w_nb_base;
    logic [LEN_WIDTH-1:0]    w_nb_rem;
    logic [31:0]             w_rem32;
    logic [DATA_WIDTH-1:0]   w_nxt_dat;
    logic [BPB-1:0]          w_nxt_keep;
    logic                    w_nxt_last;

    assign w_cfg_ok   = (pkt_len != '0) && (num_pkts != '0) && ((pkt_len % SB_L) == '0);
    assign w_acc      = r_tvalid && m_axis_tready;
    // r_rem is the byte count still owed in this packet, including the beat on the bus
    assign w_cur_last = ({1'b0, r_rem} <= BPB_X);
    assign w_run_end  = w_cur_last && (r_pkts_left == CNT_WIDTH'(1));

    always_comb begin
        w_nb_base = r_base + SPB_P;
        w_nb_rem  = r_rem - BPB_L;
        if (r_state == ST_IDLE) begin
            w_nb_base = seed;
            w_nb_rem  = pkt_len;
        end else if (w_cur_last) begin
            w_nb_base = r_pbase + PATT_WIDTH'(1);
            w_nb_rem  = r_len;
        end
    end

    // Since rem is a multiple of SB, byte validity resolves at slice granularity
    always_comb begin
        w_rem32    = 32'(w_nb_rem);
        w_nxt_dat  = '0;
        w_nxt_keep = '0;
        for (int k = 0; k < SPB; k++) begin
            if (32'(k * SB) < w_rem32)
                w_nxt_dat[k*PATT_WIDTH +: PATT_WIDTH] = w_nb_base + PATT_WIDTH'(k);
        end
        for (int i = 0; i < BPB; i++) begin
            w_nxt_keep[i] = (32'(i) < w_rem32);
        end
        w_nxt_last = ({1'b0, w_nb_rem} <= BPB_X);
    end

    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_rem       <= '0;
            r_pkts_left <= '0;
            r_pbase     <= '0;
            r_base      <= '0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_state     <= ST_SEND;
                            r_busy      <= 1'b1;
                            r_len       <= pkt_len;
                            r_rem       <= pkt_len;
                            r_pkts_left <= num_pkts;
                            r_pbase     <= seed;
                            r_base      <= seed;
                            r_tdata     <= w_nxt_dat;
                            r_tkeep     <= w_nxt_keep;
                            r_tlast     <= w_nxt_last;
                            r_tvalid    <= 1'b1;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_acc) begin
                        if (w_run_end) begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_pkts_left <= '0;
                            r_rem       <= '0;
                            r_tdata     <= '0;
                            r_tkeep     <= '0;
                            r_tlast     <= 1'b0;
                            r_tvalid    <= 1'b0;
                        end else begin
                            if (w_cur_last) begin
                                r_pkts_left <= r_pkts_left - CNT_WIDTH'(1);
                                r_pbase     <= w_nb_base;
                            end
                            r_base  <= w_nb_base;
                            r_rem   <= w_nb_rem;
                            r_tdata <= w_nxt_dat;
                            r_tkeep <= w_nxt_keep;
                            r_tlast <= w_nxt_last;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;
    assign busy          = r_busy;
    assign done          = r_done;
    assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_c2h_pattern_gen.sv
// Scoreboard bench for c2h_pattern_gen: expected beats queued per run, checked by a negedge monitor.
module tb_c2h_pattern_gen;

    logic         user_clk = 1'b0;
    logic         user_reset_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  pkt_len = '0;
    logic [15:0]  num_pkts = '0;
    logic [15:0]  seed = '0;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         busy;
    logic         done;
    logic         cfg_err;

    c2h_pattern_gen dut (
        .user_clk      (user_clk),
        .user_reset_n  (user_reset_n),
        .start         (start),
        .pkt_len       (pkt_len),
        .num_pkts      (num_pkts),
        .seed          (seed),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } beat_t;

    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    done_cnt = 0;
    int    acc_cnt = 0;
    int    busy_cyc = 0;
    bit    rand_rdy = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte j of packet p is valid iff j < len; slice at absolute byte j holds seed+p+j/2
    task automatic push_run(input int len, input int num, input logic [15:0] sd);
        int nb;
        beat_t e;
        nb = (len + 63) / 64;
        for (int p = 0; p < num; p++) begin
            for (int b = 0; b < nb; b++) begin
                e.d = '0;
                e.k = '0;
                for (int s = 0; s < 32; s++)
                    if (b*64 + s*2 < len) e.d[s*16 +: 16] = sd + 16'(p) + 16'(b*32 + s);
                for (int i = 0; i < 64; i++)
                    e.k[i] = (b*64 + i < len);
                e.l = (b == nb - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_start(input int len, input int num, input logic [15:0] sd, input bit ok);
        @(posedge user_clk); #1;
        start    = 1'b1;
        pkt_len  = 16'(len);
        num_pkts = 16'(num);
        seed     = sd;
        if (ok) push_run(len, num, sd);
        @(posedge user_clk); #1;
        start = 1'b0;
        @(negedge user_clk);
        chk("cfg_err_after_start", cfg_err, !ok);
        chk("busy_after_start", busy, ok);
        chk("tvalid_after_start", m_axis_tvalid, ok);
        if (!ok) begin
            @(negedge user_clk);
            chk("cfg_err_one_cycle", cfg_err, 0);
            chk("busy_stays_low", busy, 0);
            chk("tvalid_stays_low", m_axis_tvalid, 0);
        end
    endtask

    task automatic wait_end(input string nm);
        for (int i = 0; i < 3000; i++) begin
            @(negedge user_clk);
            if (!busy && !m_axis_tvalid) break;
        end
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_tvalid"}, m_axis_tvalid, 0);
        chk({nm, "_tlast"}, m_axis_tlast, 0);
        chk({nm, "_tkeep"}, m_axis_tkeep, 0);
        chk({nm, "_tdata"}, m_axis_tdata, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_cfg_err"}, cfg_err, 0);
    endtask

    initial begin : rdy_drv
        forever begin
            @(posedge user_clk); #1;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        bit           stalled;
        logic [511:0] h_d;
        logic [63:0]  h_k;
        logic         h_l;
        beat_t        e;
        stalled = 0;
        forever begin
            @(negedge user_clk);
            if (!user_reset_n) begin
                stalled = 0;
            end else begin
                if (stalled && m_axis_tvalid) begin
                    chk("hold_tdata", m_axis_tdata, h_d);
                    chk("hold_tkeep", m_axis_tkeep, h_k);
                    chk("hold_tlast", m_axis_tlast, h_l);
                end
                stalled = m_axis_tvalid && !m_axis_tready;
                h_d = m_axis_tdata;
                h_k = m_axis_tkeep;
                h_l = m_axis_tlast;
                if (busy) busy_cyc++;
                if (done) begin
                    done_cnt++;
                    chk("done_at_run_end", exp_q.size(), 0);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", m_axis_tvalid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", m_axis_tdata, e.d);
                        chk("tkeep", m_axis_tkeep, e.k);
                        chk("tlast", m_axis_tlast, e.l);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0, a0, len, num;
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        chk_zero("reset");
        @(posedge user_clk); #1;
        user_reset_n = 1'b1;

        // Basic 2-beat packet
        busy_cyc = 0; d0 = done_cnt; a0 = acc_cnt;
        do_start(128, 1, 16'h0010, 1);
        wait_end("t1");
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_beats", acc_cnt - a0, 2);
        chk("t1_busy_cycles", busy_cyc, 2);

        // Partial last beat and pattern wrap
        d0 = done_cnt; a0 = acc_cnt;
        do_start(70, 2, 16'hFFFE, 1);
        wait_end("t2");
        chk("t2_done_cnt", done_cnt - d0, 1);
        chk("t2_beats", acc_cnt - a0, 4);

        // Backpressure
        rand_rdy = 1; d0 = done_cnt; a0 = acc_cnt;
        do_start(200, 3, 16'h1234, 1);
        wait_end("t3");
        chk("t3_done_cnt", done_cnt - d0, 1);
        chk("t3_beats", acc_cnt - a0, 12);
        rand_rdy = 0;

        // Invalid configs
        d0 = done_cnt; a0 = acc_cnt;
        do_start(0, 1, 16'h0001, 0);
        do_start(64, 0, 16'h0001, 0);
        do_start(65, 1, 16'h0001, 0);
        chk("t4_no_beats", acc_cnt - a0, 0);
        chk("t4_no_done", done_cnt - d0, 0);

        // start during a run must be ignored
        d0 = done_cnt; a0 = acc_cnt;
        do_start(128, 2, 16'h0100, 1);
        @(posedge user_clk); #1;
        start = 1'b1; pkt_len = 16'd64; num_pkts = 16'd5; seed = 16'h7777;
        @(posedge user_clk); #1;
        start = 1'b0;
        wait_end("t5");
        chk("t5_done_cnt", done_cnt - d0, 1);
        chk("t5_beats", acc_cnt - a0, 4);

        // Reset mid-packet, then a clean restart
        d0 = done_cnt; a0 = acc_cnt;
        do_start(256, 1, 16'h0200, 1);
        for (int i = 0; i < 100 && acc_cnt < a0 + 2; i++) @(negedge user_clk);
        chk("t6_two_beats_seen", acc_cnt - a0, 2);
        @(posedge user_clk); #1;
        user_reset_n = 1'b0;
        @(posedge user_clk); #1;
        user_reset_n = 1'b1;
        @(negedge user_clk);
        chk_zero("t6_after_reset");
        chk("t6_beats_at_reset", acc_cnt - a0, 2);
        exp_q.delete();
        a0 = acc_cnt;
        do_start(256, 1, 16'h0200, 1);
        wait_end("t6b");
        chk("t6_done_cnt", done_cnt - d0, 1);
        chk("t6_clean_beats", acc_cnt - a0, 4);

        // Randomized runs under backpressure
        rand_rdy = 1;
        for (int r = 0; r < 4; r++) begin
            len = 2 * $urandom_range(1, 150);
            num = $urandom_range(1, 3);
            d0 = done_cnt; a0 = acc_cnt;
            do_start(len, num, 16'($urandom), 1);
            wait_end("rand");
            chk("rand_done_cnt", done_cnt - d0, 1);
            chk("rand_beats", acc_cnt - a0, num * ((len + 63) / 64));
        end
        rand_rdy = 0;

        repeat (3) @(negedge user_clk);
        chk("final_tvalid", m_axis_tvalid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
